// File: rtl/vga_pkg.sv
// Shared VGA subsystem types: framebuffer port ownership, buffered CPU request
// record, and the default 640x480@60 timing shared with the position counters.
package vga_pkg;

    localparam int FB_ADDR_W = 19;
    localparam int FB_DATA_W = 8;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_TOTAL_DEF  = 800;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_TOTAL_DEF  = 525;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_VGA    = 2'd1,
        OWN_CPU_WR = 2'd2,
        OWN_CPU_RD = 2'd3
    } owner_e;

    typedef struct packed {
        logic                 we;
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] wdata;
    } cpu_req_t;

endpackage

// File: rtl/vga_req_fifo.sv
// Synchronous request FIFO; full/empty are decoded from the registered count.
module vga_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display scan-out owns the port on claimed
// pixels, buffered CPU requests drain on every other cycle.
//   owner      | meaning
//   OWN_NONE   | port idle (or out-of-range write dropped)
//   OWN_VGA    | scan-out read, data goes to pix_data
//   OWN_CPU_WR | CPU write, no read data
//   OWN_CPU_RD | CPU read, data (or 0 if out of range) goes to cpu_rdata
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data
);
    localparam logic [9:0]    H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT   = 10'(V_ACTIVE);
    localparam logic [ADDR_W:0] FB_SIZE = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
    localparam int            CNT_W   = $clog2(FIFO_DEPTH) + 1;

    cpu_req_t          fifo_in;
    cpu_req_t          head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              push;
    logic              pop;

    logic              claim;
    logic              frame_start;
    logic              head_oob;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] scan_cur;

    logic              en_n;
    logic              we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    owner_e            own_n;
    logic              oob_n;

    // own_q rides with mem_*; own_d lines up with mem_rdata one clk later
    owner_e            own_q;
    owner_e            own_d;
    logic              oob_q;
    logic              oob_d;

    assign cpu_ready   = !rst && (fifo_count != CNT_W'(FIFO_DEPTH));
    assign push        = cpu_req && cpu_ready;
    assign fifo_in     = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};

    assign claim       = pix_en && (h_count < H_ACT) && (v_count < V_ACT);
    assign frame_start = pix_en && (h_count == '0) && (v_count == '0);
    assign scan_cur    = frame_start ? '0 : scan_addr;
    assign pop         = !claim && !fifo_empty;
    assign head_oob    = ({1'b0, head.addr} >= FB_SIZE);

    vga_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(cpu_req_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_in),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        en_n    = 1'b0;
        we_n    = 1'b0;
        addr_n  = '0;
        wdata_n = '0;
        own_n   = OWN_NONE;
        oob_n   = 1'b0;
        if (claim) begin
            en_n   = 1'b1;
            addr_n = scan_cur;
            own_n  = OWN_VGA;
        end else if (pop) begin
            if (head.we) begin
                if (!head_oob) begin
                    en_n    = 1'b1;
                    we_n    = 1'b1;
                    addr_n  = head.addr;
                    wdata_n = head.wdata;
                    own_n   = OWN_CPU_WR;
                end
            end else begin
                // out-of-range reads skip the RAM but keep their rvalid slot
                en_n   = !head_oob;
                addr_n = head_oob ? '0 : head.addr;
                own_n  = OWN_CPU_RD;
                oob_n  = head_oob;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            own_q     <= OWN_NONE;
            own_d     <= OWN_NONE;
            oob_q     <= 1'b0;
            oob_d     <= 1'b0;
            scan_addr <= '0;
        end else begin
            mem_en    <= en_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            own_q     <= own_n;
            own_d     <= own_q;
            oob_q     <= oob_n;
            oob_d     <= oob_q;
            if (claim) scan_addr <= scan_cur + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && fifo_full));
    end

    assign pix_valid  = (own_d == OWN_VGA);
    assign pix_data   = pix_valid ? mem_rdata : '0;
    assign cpu_rvalid = (own_d == OWN_CPU_RD);
    assign cpu_rdata  = (cpu_rvalid && !oob_d) ? mem_rdata : '0;

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port framebuffer arbiter for the VGA subsystem. Shares one synchronous RAM port between the display scan-out (hard priority, one read per active pixel) and CPU read/write requests, which are buffered in a small FIFO and drained on cycles the display does not claim. Sits between the horizontal/vertical position counters, the framebuffer RAM and the CPU memory-mapped bus.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- ADDR_W, 19, framebuffer address width; H_ACTIVE*V_ACTIVE ≤ 2**ADDR_W
- DATA_W, 8, pixel width
- FIFO_DEPTH, 4, CPU request FIFO entries (power of 2)

Ports:
- clk  in  1  clock; RAM and all state clocked on posedge
- rst  in  1  reset, synchronous, active-high
- pix_en  in  1  pixel strobe; one clk pulse per pixel
- h_count  in  10  current horizontal position
- v_count  in  10  current vertical position
- cpu_req  in  1  CPU request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  write data
- cpu_ready  out  1  FIFO can accept; a request is taken when cpu_req && cpu_ready
- cpu_rvalid  out  1  one-cycle read-data strobe
- cpu_rdata  out  DATA_W  read data, valid with cpu_rvalid
- mem_en  out  1  RAM port enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, 1 clk after mem_en
- pix_valid  out  1  pixel data strobe
- pix_data  out  DATA_W  pixel to DAC stage

## Operation

- Display claim: a cycle where pix_en=1 and h_count<H_ACTIVE and v_count<V_ACTIVE. Claimed cycle → port issues a read at scan address, scan address +1.
- Scan address: reset to 0 on every pix_en with h_count=0 and v_count=0 (before the claim check, so pixel (0,0) reads address 0). No multiplier.
- Unclaimed cycle with FIFO non-empty → pop head, issue it on the port. Display never waits.
- Port-owner register per cycle: OWN_NONE, OWN_VGA, OWN_CPU_WR, OWN_CPU_RD; selects where mem_rdata is routed next cycle.
- CPU address ≥ H_ACTIVE*V_ACTIVE: write dropped (mem_en stays 0); read returns cpu_rdata=0 with normal cpu_rvalid timing.
- cpu_ready = !full, from registered count. Push when full is impossible even with a same-cycle pop.
- Every accepted read yields exactly one cpu_rvalid, in acceptance order.
- clk must be ≥2× pixel rate, or blanking alone must cover the CPU drain; this block has no starvation timer.

## Timing

- Reset values: cpu_ready=0 during rst, 1 the cycle after; cpu_rvalid=0, cpu_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, pix_valid=0, pix_data=0; scan address 0; FIFO empty; owner OWN_NONE.
- mem_* outputs are registered: RAM access occurs 1 clk after the claim or pop decision.
- Display latency: claim cycle T → mem_en at T+1 → pix_valid/pix_data at T+2. pix_valid is high 1 cycle per claimed pixel. Downstream sync delay matches 2 clk.
- CPU minimum latency: accept at T → pop at T+1 → mem_en at T+2 → cpu_rvalid at T+3 (reads).
- Rst mid-operation: FIFO flushed, in-flight reads produce no cpu_rvalid or pix_valid, scan address 0.

## Structure

- Package vga_pkg: owner enum (OWN_NONE/OWN_VGA/OWN_CPU_WR/OWN_CPU_RD), CPU request struct {we, addr, wdata}, default timing constants shared with the position counters.
- One sub-module: vga_req_fifo (synchronous FIFO, DEPTH/width parameters, full/empty/count).

## Test plan

- Reset, then a 640×480 frame with pix_en every 2nd clk and no CPU traffic → exactly 307200 pix_valid pulses, mem_addr sequence 0…307199, then 0 at the next frame.
- CPU write addr 0x00010, data 0xA5 in blanking, then read back → cpu_rvalid 3 clk after read accept, cpu_rdata=0xA5.
- pix_en every clk during active video, 4 CPU writes pushed → cpu_ready=0 after the 4th, 5th cpu_req not accepted, FIFO drains only in blanking, pix_valid cadence unbroken.
- Write to 307200, then read 307200 → no mem_en for the write; the read returns cpu_rdata=0 with cpu_rvalid.
- Interleaved read, write, read to one address with pix_en every 2nd clk in active video → two cpu_rvalid pulses in order, second returns the written value, no pixel lost.
- Assert rst with 3 reads queued and 1 in flight → no cpu_rvalid afterwards, cpu_ready=1 one cycle after rst drops, next frame starts at mem_addr 0.
